// File: rtl/seg_display_mux.sv
// Multiplexed hex 7-segment driver with per-scan double buffering,
// leading-zero suppression and PWM brightness; all drive outputs registered.
module seg_display_mux #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  empty,
  input  logic                  lzs,
  input  logic [3:0]            bright,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  if (DIGITS < 1 || DIGITS > 8 || CLK_DIV < 2) begin : g_bad_params
    $error("seg_display_mux: DIGITS must be 1..8 and CLK_DIV at least 2");
  end

  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            pwm_cnt_q, pwm_cnt_d;
  logic [4*DIGITS-1:0]   act_num_q, act_num_d;
  logic [DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [4*DIGITS-1:0]   pend_num_q, pend_num_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q;

  logic                  tick;
  logic                  last_digit;
  logic                  scan_end;
  logic                  lit;
  logic                  show;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_zero;
  logic [DIGITS-1:0]     zero_from;
  logic                  suppress;

  assign tick       = (div_cnt_q == DW'(CLK_DIV - 1));
  assign last_digit = (idx_q == IW'(DIGITS - 1));
  assign scan_end   = tick && last_digit;

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    idx_d     = idx_q;
    if (tick) begin
      idx_d = last_digit ? '0 : idx_q + IW'(1);
    end
    pwm_cnt_d = pwm_cnt_q + 4'd1;
  end

  // A load on the scan boundary bypasses the pending buffer entirely.
  always_comb begin
    act_num_d  = act_num_q;
    act_dp_d   = act_dp_q;
    pend_num_d = pend_num_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (scan_end) begin
      pend_vld_d = 1'b0;
      if (load) begin
        act_num_d = number;
        act_dp_d  = dp_in;
      end else if (pend_vld_q) begin
        act_num_d = pend_num_q;
        act_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_num_d = number;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  // zero_from[i]: every active nibble from i up to the most significant is zero.
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (act_num_q[4*(DIGITS-1) +: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (act_num_q[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib  = act_num_q[4*i +: 4];
        cur_dp   = act_dp_q[i];
        cur_zero = zero_from[i];
      end
    end
  end

  assign lit      = (bright == 4'hF) || (pwm_cnt_q < bright);
  assign show     = lit && !empty;
  assign suppress = lzs && (idx_q != '0) && cur_zero;

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = '1;
    if (show) begin
      seg_d = suppress ? SEG_OFF : hex7(cur_nib);
      dp_d  = ~cur_dp;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (show && (idx_q == IW'(i))) begin
        an_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      idx_q      <= '0;
      pwm_cnt_q  <= '0;
      act_num_q  <= '0;
      act_dp_q   <= '0;
      pend_num_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= '1;
      frame_q    <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      pwm_cnt_q  <= pwm_cnt_d;
      act_num_q  <= act_num_d;
      act_dp_q   <= act_dp_d;
      pend_num_q <= pend_num_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= scan_end;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Drives DIGITS = 4, 1 and 8 instances (CLK_DIV = 4) from shared stimulus and
// checks every output each cycle against a time-indexed reference model.
module tb_seg_display_mux;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] num = '0;
  logic [7:0]  dpi = '0;
  logic        load = 1'b0;
  logic        empty = 1'b0;
  logic        lzs = 1'b0;
  logic [3:0]  bright = 4'hF;

  logic [6:0] seg4, seg1, seg8;
  logic       dp4, dp1, dp8;
  logic [3:0] an4;
  logic [0:0] an1;
  logic [7:0] an8;
  logic       fr4, fr1, fr8;

  always #5 clk = ~clk;

  seg_display_mux #(.DIGITS(4), .CLK_DIV(C)) u_d4 (
    .clk(clk), .rst(rst), .number(num[15:0]), .dp_in(dpi[3:0]), .load(load),
    .empty(empty), .lzs(lzs), .bright(bright),
    .seg(seg4), .dp(dp4), .an(an4), .frame(fr4));

  seg_display_mux #(.DIGITS(1), .CLK_DIV(C)) u_d1 (
    .clk(clk), .rst(rst), .number(num[3:0]), .dp_in(dpi[0:0]), .load(load),
    .empty(empty), .lzs(lzs), .bright(bright),
    .seg(seg1), .dp(dp1), .an(an1), .frame(fr1));

  seg_display_mux #(.DIGITS(8), .CLK_DIV(C)) u_d8 (
    .clk(clk), .rst(rst), .number(num), .dp_in(dpi), .load(load),
    .empty(empty), .lzs(lzs), .bright(bright),
    .seg(seg8), .dp(dp8), .an(an8), .frame(fr8));

  // Reference model: edges since reset release plus displayed/pending words.
  int unsigned t;
  logic [31:0] act_n  [3];
  logic [7:0]  act_d  [3];
  logic [31:0] pend_n [3];
  logic [7:0]  pend_d [3];
  bit          pflag  [3];
  int          last_fr[3];
  int          cyc;
  int          n_cmp;
  int          n_err;
  logic [6:0]  hex_tab [16];

  function automatic int dg(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 8;
  endfunction

  function automatic logic [31:0] nmask(input int d);
    return (d >= 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * d)) - 32'h1);
  endfunction

  function automatic logic [7:0] dmask(input int d);
    return (d >= 8) ? 8'hFF : 8'((9'h1 << d) - 9'h1);
  endfunction

  function automatic logic [6:0] got_seg(input int k);
    return (k == 0) ? seg4 : (k == 1) ? seg1 : seg8;
  endfunction

  function automatic logic got_dp(input int k);
    return (k == 0) ? dp4 : (k == 1) ? dp1 : dp8;
  endfunction

  function automatic logic [7:0] got_an(input int k);
    return (k == 0) ? {4'h0, an4} : (k == 1) ? {7'h0, an1} : an8;
  endfunction

  function automatic logic got_fr(input int k);
    return (k == 0) ? fr4 : (k == 1) ? fr1 : fr8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int k = 0; k < 3; k++) begin
      act_n[k] = '0; act_d[k] = '0; pend_n[k] = '0; pend_d[k] = '0; pflag[k] = 1'b0;
    end
  endtask

  // Predict the registered outputs from pre-edge state, clock once, compare.
  task automatic step();
    logic [6:0] es [3];
    logic       ed [3];
    logic [7:0] ea [3];
    logic       ef [3];
    for (int k = 0; k < 3; k++) begin
      int d = dg(k);
      es[k] = 7'h7F; ed[k] = 1'b1; ea[k] = dmask(d); ef[k] = 1'b0;
      if (!rst) begin
        int          idx   = int'((t / C) % d);
        bit          on    = ((bright == 4'hF) || ((t % 16) < bright)) && !empty;
        bit          bnd   = ((t + 1) % (C * d)) == 0;
        logic [31:0] upper = act_n[k] >> (4 * idx);
        if (on) begin
          es[k] = (lzs && idx > 0 && upper == 0) ? 7'h7F : hex_tab[upper[3:0]];
          ed[k] = ~act_d[k][idx];
          ea[k] = dmask(d) & ~(8'h1 << idx);
        end
        ef[k] = bnd;
        if (bnd) begin
          if (load) begin
            act_n[k] = num & nmask(d); act_d[k] = dpi & dmask(d);
          end else if (pflag[k]) begin
            act_n[k] = pend_n[k]; act_d[k] = pend_d[k];
          end
          pflag[k] = 1'b0;
        end else if (load) begin
          pend_n[k] = num & nmask(d); pend_d[k] = dpi & dmask(d); pflag[k] = 1'b1;
        end
      end
    end
    if (rst) model_reset();
    else t++;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      string sfx = $sformatf("_D%0d", dg(k));
      chk({"seg", sfx}, 32'(got_seg(k)), 32'(es[k]));
      chk({"dp", sfx}, 32'(got_dp(k)), 32'(ed[k]));
      chk({"an", sfx}, 32'(got_an(k)), 32'(ea[k]));
      chk({"frame", sfx}, 32'(got_fr(k)), 32'(ef[k]));
      if (got_fr(k) && last_fr[k] >= 0) begin
        chk({"frame_gap", sfx}, 32'(cyc - last_fr[k]), 32'(C * dg(k)));
      end
      if (got_fr(k)) last_fr[k] = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] d);
    num = v; dpi = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic release_rst();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) last_fr[k] = cyc;
  endtask

  task automatic count_on(input string tag, input logic [3:0] b, input int exp);
    int cnt = 0;
    bright = b;
    for (int i = 0; i < 64; i++) begin
      step();
      if (an4 != 4'hF) cnt++;
    end
    chk(tag, 32'(cnt), 32'(exp));
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    n_cmp = 0; n_err = 0; cyc = 0;
    for (int k = 0; k < 3; k++) last_fr[k] = -1;
    model_reset();

    run(2);
    release_rst();
    run(5);
    do_load(32'h0000_1234, 8'h00);
    run(40);

    lzs = 1'b1;
    do_load(32'h0000_0050, 8'h00);
    run(40);
    lzs = 1'b0;
    run(20);

    while (((t + 1) % 16) == 0 || (t % 16) < 3) step();
    do_load(32'hABCD_ABCD, 8'h05);
    run(20);
    while (((t + 1) % 16) != 0) step();
    do_load(32'h1F2E_3D4C, 8'hA3);
    run(20);

    count_on("bright4_on", 4'h4, 16);
    count_on("bright0_on", 4'h0, 0);
    bright = 4'hF;
    empty = 1'b1;
    run(10);
    empty = 1'b0;
    run(5);

    while (((t + 1) % 16) == 0) step();
    do_load(32'h5678_9ABC, 8'hFF);
    run(1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_seg", 32'(seg4), 32'h7F);
    chk("arst_dp", 32'(dp4), 32'h1);
    chk("arst_an", 32'(an4), 32'hF);
    chk("arst_frame", 32'(fr4), 32'h0);
    chk("arst_an_D8", 32'(an8), 32'hFF);
    chk("arst_seg_D1", 32'(seg1), 32'h7F);
    run(2);
    release_rst();
    run(40);

    for (int i = 0; i < 1500; i++) begin
      num   = $urandom;
      dpi   = 8'($urandom);
      load  = ($urandom_range(0, 11) == 0);
      empty = ($urandom_range(0, 24) == 0);
      if ((i % 50) == 0) lzs = 1'($urandom);
      if ((i % 64) == 0) bright = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      if ((i % 37) == 0) num = num & 32'h0000_0F0F;
      step();
    end
    load = 1'b0;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
